// File: rtl/cpu_types_pkg.sv
// Shared types for the MIPS core: register-field type, hazard sequencer
// state and the bundle of pipeline-latch controls it drives.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        DRAIN,
        HALTED
    } hzstate_t;

    // Enables/clears for the PC and the four pipeline latches
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_FREEZE  = '0;
    localparam pipe_ctrl_t CTRL_ADVANCE = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                           idex_en: 1'b1, idex_flush: 1'b0,
                                           exmem_en: 1'b1, memwb_en: 1'b1};
    // Hold PC and IF/ID, inject a bubble into ID/EX, let the back end advance
    localparam pipe_ctrl_t CTRL_BUBBLE  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
                                           idex_en: 1'b1, idex_flush: 1'b1,
                                           exmem_en: 1'b1, memwb_en: 1'b1};

    // Issue decision once the pipe is free to move: branch > load-use > jump
    function automatic pipe_ctrl_t issue_ctrl(input logic branch, input logic lu,
                                              input logic jump);
        pipe_ctrl_t c;
        c = CTRL_ADVANCE;
        if (branch) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (lu) begin
            c = CTRL_BUBBLE;
        end else if (jump) begin
            c.ifid_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Ports: clk, rst, inc (count enable), count (current value, sticks at all-ones).
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core. Drives PC and latch
// enables/flushes to resolve load-use hazards, taken branches, jumps,
// dcache waits and halt drain; keeps saturating stall/flush counters.
// Ports: CLK/RST (async, active high); ihit/dhit cache status;
// mem_dmemreq, ex_memread/ex_rt, id_rs/id_rt/id_uses_rt hazard inputs;
// jump_id, branch_taken, halt_mem control events; latch enables/flushes,
// sticky halted flag, stall_cnt and flush_cnt statistics.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DRAIN_CYC = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dmemreq,
    input  logic             ex_memread,
    input  regbits_t         ex_rt,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  logic             id_uses_rt,
    input  logic             jump_id,
    input  logic             branch_taken,
    input  logic             halt_mem,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             flush_IDEX,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    hzstate_t     state, state_nxt;
    logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
    pipe_ctrl_t   ctl;
    logic         dwait, lu, flush_inc, stall_inc;

    // State and drain-counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    // Next state and combinational latch controls
    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        ctl       = CTRL_FREEZE;
        flush_inc = 1'b0;
        dwait     = mem_dmemreq & ~dhit;
        lu        = ex_memread && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

        case (state)
            RUN: begin
                if (halt_mem) begin
                    ctl.memwb_en = 1'b1;
                    drain_nxt    = DRAIN_W'(DRAIN_CYC - 1);
                    state_nxt    = (DRAIN_CYC > 1) ? DRAIN : HALTED;
                end else if (dwait) begin
                    state_nxt = MEMWAIT;
                end else if (ihit) begin
                    ctl       = issue_ctrl(branch_taken, lu, jump_id);
                    flush_inc = branch_taken;
                end
            end
            MEMWAIT: begin
                if (dhit) begin
                    state_nxt = RUN;
                    if (ihit) begin
                        ctl       = issue_ctrl(branch_taken, lu, jump_id);
                        flush_inc = branch_taken;
                    end else begin
                        ctl = CTRL_BUBBLE;
                    end
                end
            end
            DRAIN: begin
                ctl.memwb_en = 1'b1;
                // drain_cnt holds the remaining drain cycles including this one
                if (drain_cnt <= DRAIN_W'(1)) begin
                    state_nxt = HALTED;
                end else begin
                    drain_nxt = drain_cnt - DRAIN_W'(1);
                end
            end
            HALTED: begin
                ctl = CTRL_FREEZE;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // Nothing moves while reset is held
        if (RST) begin
            ctl       = CTRL_FREEZE;
            flush_inc = 1'b0;
        end

        stall_inc = ((state == RUN) || (state == MEMWAIT)) && !ctl.pc_en && !RST;
    end

    assign pc_en      = ctl.pc_en;
    assign ifid_en    = ctl.ifid_en;
    assign ifid_flush = ctl.ifid_flush;
    assign idex_en    = ctl.idex_en;
    assign flush_IDEX = ctl.idex_flush;
    assign exmem_en   = ctl.exmem_en;
    assign memwb_en   = ctl.memwb_en;
    assign halted     = (state == HALTED);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage MIPS core.
- Drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB latches: the ID/EX `ihit` enable and `flush_IDEX` are driven by this block.
- Resolves load-use hazards, taken branches and jumps, dcache wait and halt drain.
- Keeps saturating stall and flush statistics counters.

Parameters:
- CNT_W, 16: width of the statistics counters.
- DRAIN_CYC, 1: cycles MEM/WB keeps advancing after a halt reaches MEM.

Ports:
- CLK  in  1  core clock, rising edge.
- RST  in  1  asynchronous reset, active high.
- ihit  in  1  icache hit this cycle.
- dhit  in  1  dcache hit this cycle.
- mem_dmemreq  in  1  EX/MEM holds a load or store.
- ex_memread  in  1  ID/EX holds a load.
- ex_rt  in  5  load destination register in ID/EX.
- id_rs  in  5  IF/ID source register rs.
- id_rt  in  5  IF/ID source register rt.
- id_uses_rt  in  1  IF/ID instruction reads rt.
- jump_id  in  1  J/JAL/JR decoded in ID.
- branch_taken  in  1  branch resolved taken in EX/MEM.
- halt_mem  in  1  HALT in EX/MEM.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID latch enable.
- ifid_flush  out  1  IF/ID clear (acts only with ifid_en).
- idex_en  out  1  ID/EX enable (the latch's ihit input).
- flush_IDEX  out  1  ID/EX clear (acts only with idex_en).
- exmem_en  out  1  EX/MEM latch enable.
- memwb_en  out  1  MEM/WB latch enable.
- halted  out  1  core halted, sticky.
- stall_cnt  out  CNT_W  cycles with pc_en=0, excluding DRAIN and HALTED.
- flush_cnt  out  CNT_W  taken-branch flush events.

Behaviour:
- One clock CLK; RST is asynchronous, active high.
- Reset: state=RUN, both counters 0, halted=0. While RST is high all enables and flushes are 0.
- FSM states: RUN, MEMWAIT, DRAIN, HALTED. Outputs are combinational from state and inputs.
- Definitions: `dwait = mem_dmemreq & !dhit`. `lu = ex_memread & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))`.

RUN, evaluated in priority order:
- halt_mem: all enables 0 except memwb_en=1. Go to DRAIN, loading the drain counter with DRAIN_CYC-1. When DRAIN_CYC=1, go directly to HALTED.
- dwait: all enables 0. Go to MEMWAIT.
- !ihit: all enables 0 (whole-pipe freeze). Stay in RUN.
- branch_taken: all enables 1, ifid_flush=1, flush_IDEX=1. Increment flush_cnt. Branch beats lu and jump_id in the same cycle.
- lu: pc_en=0, ifid_en=0, idex_en=1 with flush_IDEX=1 (bubble), exmem_en=1, memwb_en=1. The stall lasts exactly one cycle because the bubble clears the hazard.
- jump_id: all enables 1, ifid_flush=1.
- Otherwise: all enables 1, no flushes.

MEMWAIT:
- While !dhit: all enables 0.
- On dhit with ihit: behave as the RUN non-halt branch rules above, then go to RUN.
- On dhit with !ihit: pc_en=0, ifid_en=0, idex_en=1 with flush_IDEX=1, exmem_en=1, memwb_en=1, then go to RUN.

DRAIN:
- memwb_en=1, all other enables 0.
- Count down; at 0 go to HALTED.

HALTED:
- All enables 0, halted=1. Remains until RST.

Counters:
- Saturate at all-ones; no wrap.
- stall_cnt increments on any RUN/MEMWAIT cycle with pc_en=0.
- RST mid-operation clears everything immediately (asynchronous).

Decomposition:
- cpu_types_pkg gains `hzstate_t` (enum RUN/MEMWAIT/DRAIN/HALTED) and `regbits_t` use for register fields.
- One sub-module, `sat_counter`, parameterised by width, with increment enable and async high reset. It is instantiated twice.

Test Plan:
- LW $2 then ADD $3,$2,$4 with ihit=1: one cycle with pc_en=0, ifid_en=0, idex_en=1, flush_IDEX=1; stall_cnt=1; next cycle all enables 1.
- Load-use with ex_rt=0: no stall; all enables 1; stall_cnt stays 0.
- branch_taken=1 with lu=1 in the same cycle: ifid_flush=1, flush_IDEX=1, pc_en=1; flush_cnt=1.
- mem_dmemreq=1, dhit=0 for 3 cycles, then dhit=1 with ihit=0: 3 cycles all enables 0, then idex bubble with exmem_en=memwb_en=1 and pc_en=0; stall_cnt=4; state RUN.
- halt_mem=1 with DRAIN_CYC=1: memwb_en=1 only that cycle; then halted=1 and all enables 0; all inputs toggling afterwards have no effect.
- Assert RST mid-MEMWAIT: outputs drop to 0 without a clock edge; counters 0; after release state=RUN.
- Force 2^CNT_W+5 stall cycles: stall_cnt holds at 0xFFFF.
